// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the byte-coded instruction sequencer: opcodes,
// FSM state encoding and the opcode-to-operand-count decoder.
package instr_pkg;

    localparam logic [7:0] OPC_UNARY  = 8'h01;
    localparam logic [7:0] OPC_BINARY = 8'h02;
    localparam logic [7:0] OPC_ACC    = 8'h03;
    localparam logic [7:0] OPC_JMP    = 8'h04;
    localparam logic [7:0] OPC_JZ     = 8'h05;
    localparam logic [7:0] OPC_HALT   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OPC = 3'd1,
        ST_FETCH_ARG = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_ALU  = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    // Operand byte count; zero means the opcode carries no operands (HALT or undefined).
    function automatic logic [1:0] instr_len(input logic [7:0] opc);
        logic [1:0] len;
        case (opc)
            OPC_UNARY:  len = 2'd2;
            OPC_BINARY: len = 2'd3;
            OPC_ACC:    len = 2'd2;
            OPC_JMP:    len = 2'd2;
            OPC_JZ:     len = 2'd2;
            default:    len = 2'd0;
        endcase
        return len;
    endfunction

    function automatic logic uses_alu(input logic [7:0] opc);
        return (opc == OPC_UNARY) || (opc == OPC_BINARY) || (opc == OPC_ACC);
    endfunction

endpackage

// File: rtl/instr_sequencer_fetch.sv
// Program counter and two-cycle byte fetch sequencing (strobe cycle, then
// capture cycle), including wrap-around and jump loading.
module instr_fetch_unit #(
    parameter int          ADDR_W     = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              req,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              byte_valid
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1'b1);

    logic [ADDR_W-1:0] pc_r;
    logic              phase_r;

    // PC and fetch phase; the PC advances (or jumps) only in the capture cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= START_PC;
            phase_r <= 1'b0;
        end else if (load) begin
            pc_r    <= START_PC;
            phase_r <= 1'b0;
        end else if (req && !phase_r) begin
            phase_r <= 1'b1;
        end else if (req && phase_r) begin
            phase_r <= 1'b0;
            pc_r    <= jump ? jump_target : (pc_r + PC_STEP);
        end else begin
            phase_r <= 1'b0;
        end
    end

    // Memory strobe and capture qualifier decoded from the phase bit.
    always_comb begin
        mem_rd_en  = req && !phase_r;
        byte_valid = req && phase_r;
        if (mem_rd_en) begin
            mem_addr = pc_r;
        end else begin
            mem_addr = '0;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: decodes variable-length byte instructions fetched
// from program memory and drives the ALU over a start/done handshake.
module instr_sequencer
    import instr_pkg::*;
#(
    parameter int          DATA_W     = 8,
    parameter int          ADDR_W     = 10,
    parameter int          OP_W       = 6,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_done,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              running,
    output logic              halted,
    output logic              illegal
);

    state_t            state_r;
    state_t            state_n_s;
    logic [7:0]        opc_r;
    logic [1:0]        arg_cnt_r;
    logic [DATA_W-1:0] lo_r;
    logic [OP_W-1:0]   alu_op_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [DATA_W-1:0] result_r;
    logic              result_valid_r;
    logic              zero_r;
    logic              illegal_r;

    logic              fetch_req_s;
    logic              load_s;
    logic              jump_s;
    logic              byte_valid_s;
    logic              last_arg_s;
    logic              opc_cap_s;
    logic              arg_cap_s;
    logic              done_s;
    logic [7:0]        opc_byte_s;
    logic [ADDR_W-1:0] jump_target_s;

    assign opc_byte_s    = mem_rdata[7:0];
    assign jump_target_s = ADDR_W'({mem_rdata, lo_r});

    instr_fetch_unit #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR)
    ) u_fetch (
        .clk         (clk),
        .reset       (reset),
        .load        (load_s),
        .req         (fetch_req_s),
        .jump        (jump_s),
        .jump_target (jump_target_s),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .byte_valid  (byte_valid_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic, fetch control and capture strobes.
    always_comb begin
        state_n_s   = state_r;
        fetch_req_s = 1'b0;
        load_s      = 1'b0;
        jump_s      = 1'b0;
        opc_cap_s   = 1'b0;
        arg_cap_s   = 1'b0;
        done_s      = 1'b0;
        last_arg_s  = (arg_cnt_r == (instr_len(opc_r) - 2'd1));
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    load_s    = 1'b1;
                    state_n_s = ST_FETCH_OPC;
                end else begin
                    state_n_s = state_r;
                end
            end
            ST_FETCH_OPC: begin
                fetch_req_s = 1'b1;
                opc_cap_s   = byte_valid_s;
                if (byte_valid_s) begin
                    if (instr_len(opc_byte_s) != 2'd0) begin
                        state_n_s = ST_FETCH_ARG;
                    end else begin
                        state_n_s = ST_HALT;
                    end
                end else begin
                    state_n_s = state_r;
                end
            end
            ST_FETCH_ARG: begin
                fetch_req_s = 1'b1;
                arg_cap_s   = byte_valid_s;
                if (byte_valid_s && last_arg_s) begin
                    if (uses_alu(opc_r)) begin
                        state_n_s = ST_ISSUE;
                    end else begin
                        // Jump target high byte is on mem_rdata right now.
                        jump_s    = (opc_r == OPC_JMP) || ((opc_r == OPC_JZ) && zero_r);
                        state_n_s = ST_FETCH_OPC;
                    end
                end else begin
                    state_n_s = state_r;
                end
            end
            ST_ISSUE: begin
                state_n_s = ST_WAIT_ALU;
            end
            ST_WAIT_ALU: begin
                done_s = alu_done;
                if (alu_done) begin
                    state_n_s = ST_FETCH_OPC;
                end else begin
                    state_n_s = state_r;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, accumulator, zero flag and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            opc_r          <= 8'h00;
            arg_cnt_r      <= 2'd0;
            lo_r           <= '0;
            alu_op_r       <= '0;
            alu_a_r        <= '0;
            alu_b_r        <= '0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            zero_r         <= 1'b0;
            illegal_r      <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            if (load_s) begin
                illegal_r <= 1'b0;
            end
            if (opc_cap_s) begin
                opc_r     <= opc_byte_s;
                arg_cnt_r <= 2'd0;
                if ((instr_len(opc_byte_s) == 2'd0) && (opc_byte_s != OPC_HALT)) begin
                    illegal_r <= 1'b1;
                end
            end
            if (arg_cap_s) begin
                arg_cnt_r <= arg_cnt_r + 2'd1;
                case (opc_r)
                    OPC_UNARY: begin
                        if (arg_cnt_r == 2'd0) begin
                            alu_op_r <= mem_rdata[OP_W-1:0];
                        end else begin
                            alu_a_r <= mem_rdata;
                            alu_b_r <= '0;
                        end
                    end
                    OPC_BINARY: begin
                        if (arg_cnt_r == 2'd0) begin
                            alu_op_r <= mem_rdata[OP_W-1:0];
                        end else if (arg_cnt_r == 2'd1) begin
                            alu_a_r <= mem_rdata;
                        end else begin
                            alu_b_r <= mem_rdata;
                        end
                    end
                    OPC_ACC: begin
                        if (arg_cnt_r == 2'd0) begin
                            alu_op_r <= mem_rdata[OP_W-1:0];
                        end else begin
                            alu_a_r <= result_r;
                            alu_b_r <= mem_rdata;
                        end
                    end
                    default: begin
                        lo_r <= mem_rdata;
                    end
                endcase
            end
            if (done_s) begin
                result_r       <= alu_result;
                zero_r         <= (alu_result == '0);
                result_valid_r <= 1'b1;
            end
        end
    end

    assign alu_start    = (state_r == ST_ISSUE);
    assign alu_op       = alu_op_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign running      = (state_r != ST_IDLE) && (state_r != ST_HALT);
    assign halted       = (state_r == ST_HALT);
    assign illegal      = illegal_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a behavioural program
// memory and a fixed-latency ALU (op 6 subtracts, anything else adds).
module tb_instr_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int OP_W   = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata = 8'h00;
    logic              alu_start;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result = 8'h00;
    logic              alu_done = 1'b0;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              running;
    logic              halted;
    logic              illegal;

    logic [7:0]        mem [0:1023];
    logic [ADDR_W-1:0] last_addr = '0;
    logic [7:0]        alu_pend = 8'h00;
    int                fetch_count = 0;
    int                alu_starts = 0;
    int                alu_cnt = 0;
    int                total = 0;
    int                bad = 0;

    instr_sequencer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .OP_W       (OP_W),
        .START_ADDR (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .alu_start    (alu_start),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_done     (alu_done),
        .result       (result),
        .result_valid (result_valid),
        .running      (running),
        .halted       (halted),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mem_rdata   <= mem[mem_addr];
            last_addr   <= mem_addr;
            fetch_count <= fetch_count + 1;
        end
    end

    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (alu_start === 1'b1) begin
            alu_cnt    <= 2;
            alu_starts <= alu_starts + 1;
            alu_pend   <= (alu_op == 6'd6) ? (alu_a - alu_b) : (alu_a + alu_b);
        end else if (alu_cnt > 1) begin
            alu_cnt <= alu_cnt - 1;
        end else if (alu_cnt == 1) begin
            alu_cnt    <= 0;
            alu_done   <= 1'b1;
            alu_result <= alu_pend;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return alu_start;
            1:       return result_valid;
            2:       return halted;
            default: return mem_rd_en;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag, output int n);
        n = 0;
        while (sig(sel) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 16'(sig(sel)), 16'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    endtask

    initial begin
        int n;
        int n0;
        reset = 1'b1;
        start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mem_addr", 16'(mem_addr), 16'h0);
        check("rst_rd_en", 16'(mem_rd_en), 16'h0);
        check("rst_alu_start", 16'(alu_start), 16'h0);
        check("rst_alu_op", 16'(alu_op), 16'h0);
        check("rst_alu_a", 16'(alu_a), 16'h0);
        check("rst_alu_b", 16'(alu_b), 16'h0);
        check("rst_result", 16'(result), 16'h0);
        check("rst_flags", 16'({result_valid, running, halted, illegal}), 16'h0);

        // BINARY add 3+4 then HALT
        mem[0] = 8'h02; mem[1] = 8'h05; mem[2] = 8'h03; mem[3] = 8'h04; mem[4] = 8'hFF;
        pulse_start();
        check("t1_fetch_en", 16'(mem_rd_en), 16'h1);
        check("t1_fetch_addr", 16'(mem_addr), 16'h0);
        wait_for(0, 20, "t1_alu_start_seen", n);
        check("t1_binary_latency", 16'(n), 16'd8);
        check("t1_alu_op", 16'(alu_op), 16'h05);
        check("t1_alu_a", 16'(alu_a), 16'h03);
        check("t1_alu_b", 16'(alu_b), 16'h04);
        @(negedge clk);
        check("t1_start_one_cycle", 16'(alu_start), 16'h0);
        wait_for(1, 20, "t1_valid_seen", n);
        check("t1_done_latency", 16'(n), 16'd3);
        check("t1_result", 16'(result), 16'h07);
        @(negedge clk);
        check("t1_valid_pulse", 16'(result_valid), 16'h0);
        wait_for(2, 20, "t1_halt_seen", n);
        check("t1_illegal", 16'(illegal), 16'h0);
        check("t1_running", 16'(running), 16'h0);
        n0 = fetch_count;
        repeat (5) @(negedge clk);
        check("t1_halt_no_fetch", 16'(fetch_count), 16'(n0));
        check("t1_alu_starts", 16'(alu_starts), 16'd1);

        // Accumulator chain to zero, JZ taken to 0x20
        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h05; mem[2] = 8'h06; mem[3] = 8'h06;
        mem[4] = 8'h03; mem[5] = 8'h06; mem[6] = 8'h0C;
        mem[7] = 8'h05; mem[8] = 8'h20; mem[9] = 8'h00;
        pulse_start();
        check("t2_result_kept", 16'(result), 16'h07);
        wait_for(1, 30, "t2_valid1_seen", n);
        check("t2_result_add", 16'(result), 16'h0C);
        wait_for(0, 30, "t2_acc_start_seen", n);
        check("t2_acc_latency", 16'(n), 16'd6);
        check("t2_acc_a_chain", 16'(alu_a), 16'h0C);
        check("t2_acc_b", 16'(alu_b), 16'h0C);
        check("t2_acc_op", 16'(alu_op), 16'h06);
        wait_for(1, 30, "t2_valid2_seen", n);
        check("t2_result_zero", 16'(result), 16'h00);
        wait_for(2, 30, "t2_halt_seen", n);
        check("t2_jz_target", 16'(last_addr), 16'h020);

        // Undefined opcode
        clear_mem();
        mem[0] = 8'h7E;
        n0 = alu_starts;
        pulse_start();
        wait_for(2, 20, "t3_halt_seen", n);
        check("t3_illegal_set", 16'(illegal), 16'h1);
        check("t3_no_alu", 16'(alu_starts), 16'(n0));
        check("t3_running", 16'(running), 16'h0);
        pulse_start();
        check("t3_illegal_clear", 16'(illegal), 16'h0);
        check("t3_running_again", 16'(running), 16'h1);
        wait_for(2, 20, "t3_halt2_seen", n);
        check("t3_illegal_again", 16'(illegal), 16'h1);

        // Reset while waiting on the ALU
        mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'h09; mem[3] = 8'hFF;
        pulse_start();
        wait_for(0, 20, "t4_alu_start_seen", n);
        check("t4_unary_latency", 16'(n), 16'd6);
        check("t4_alu_a", 16'(alu_a), 16'h09);
        check("t4_alu_b", 16'(alu_b), 16'h00);
        @(negedge clk);
        check("t4_waiting", 16'(running), 16'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_rst_flags", 16'({result_valid, running, halted, illegal}), 16'h0);
        check("t4_rst_alu_op", 16'(alu_op), 16'h0);
        check("t4_rst_alu_a", 16'(alu_a), 16'h0);
        check("t4_rst_result", 16'(result), 16'h0);
        check("t4_rst_mem", 16'({mem_rd_en, mem_addr}), 16'h0);
        @(negedge clk);
        check("t4_late_done_valid", 16'(result_valid), 16'h0);
        @(negedge clk);
        check("t4_late_done_result", 16'(result), 16'h0);
        check("t4_still_idle", 16'({running, halted, alu_start}), 16'h0);

        // JMP to last address, UNARY operands wrap to 0, start while running
        clear_mem();
        mem[0] = 8'h04; mem[1] = 8'hFF; mem[2] = 8'h03;
        mem[3] = 8'h05; mem[4] = 8'h11; mem[5] = 8'hFF;
        mem[1023] = 8'h01;
        pulse_start();
        n = 0;
        while (!(mem_rd_en === 1'b1 && mem_addr == 10'h3FF) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_jmp_latency", 16'(n), 16'd6);
        repeat (2) @(negedge clk);
        check("t5_wrap_addr", 16'({mem_rd_en, mem_addr}), 16'h0400);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_start_ignored_run", 16'(running), 16'h1);
        @(negedge clk);
        check("t5_fetch_continues", 16'({mem_rd_en, mem_addr}), 16'h0401);
        wait_for(0, 20, "t5_unary_seen", n);
        check("t5_unary_tail", 16'(n), 16'd2);
        check("t5_unary_op", 16'(alu_op), 16'h04);
        check("t5_unary_a", 16'(alu_a), 16'hFF);
        check("t5_unary_b", 16'(alu_b), 16'h00);
        wait_for(1, 20, "t5_valid_seen", n);
        check("t5_result1", 16'(result), 16'hFF);
        wait_for(0, 20, "t5_acc_seen", n);
        check("t5_acc_a", 16'(alu_a), 16'hFF);
        check("t5_acc_b", 16'(alu_b), 16'h11);
        wait_for(2, 30, "t5_halt_seen", n);
        check("t5_result2", 16'(result), 16'h10);
        check("t5_illegal", 16'(illegal), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
